// File: rtl/sdram_lcd_pkg.sv
// Shared definitions for the SDRAM-to-LCD read path.
// Provides a constant-evaluable clog2, a minimum-width helper and the
// default word geometry for the 480x272 panel (16-bit SDRAM words,
// six per 96-bit packed word, 195840 SDRAM words per frame).
package sdram_lcd_pkg;

    localparam int DEF_IN_W        = 16;
    localparam int DEF_RATIO       = 6;
    localparam int LCD_FRAME_WORDS = 480 * 272 * 3 / 2;

    // Ceiling log2; clog2(0) = clog2(1) = 0.
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Counter widths never drop to zero bits.
    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO with occupancy count.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_push/i_push_data  write request and data (dropped when full unless popping)
//   i_pop           read request (ignored when empty)
//   o_data          head entry, zero when empty
//   o_valid/o_full  non-empty / full flags
//   o_count         registered number of stored entries
module sync_fifo_sa
    import sdram_lcd_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4,
    localparam int CW   = clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic [CW-1:0]    o_count
);

    localparam int AW = max1(clog2(DEPTH));

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A push at full is legal when the head leaves on the same edge.
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
        end
    end

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/sdram_word_packer.sv
// Packs RATIO consecutive IN_W-bit SDRAM words into one OUT_W-bit pixel word.
// Ports:
//   clk_ref, rst_n          clock, synchronous active-low reset
//   frame_sync              realign to start of frame, drops any partial word
//   in_valid/in_data/in_ready    input stream
//   out_valid/out_data/out_ready output stream (show-ahead buffer head)
//   frame_done              pulse after the last word of a frame is accepted
//   partial_drop            pulse when frame_sync discarded a partial word
//   fill_level              packed words waiting in the output buffer
module sdram_word_packer
    import sdram_lcd_pkg::*;
#(
    parameter int IN_W        = DEF_IN_W,
    parameter int RATIO       = DEF_RATIO,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int FRAME_WORDS = LCD_FRAME_WORDS,
    parameter int FIFO_DEPTH  = 4,
    localparam int OUT_W      = IN_W * RATIO,
    localparam int FL_W       = clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk_ref,
    input  logic             rst_n,
    input  logic             frame_sync,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic             frame_done,
    output logic             partial_drop,
    output logic [FL_W-1:0]  fill_level
);

    localparam int LW        = max1(clog2(RATIO));
    localparam int FW        = max1(clog2(FRAME_WORDS));
    localparam int LANE0_LSB = MSB_FIRST ? (RATIO - 1) * IN_W : 0;

    if (RATIO < 1 || FRAME_WORDS < 1 || (FRAME_WORDS % RATIO) != 0) begin : g_bad_frame
        $error("sdram_word_packer: FRAME_WORDS must be a nonzero multiple of RATIO");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sdram_word_packer: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic [LW-1:0]    r_lane;
    logic [FW-1:0]    r_frame_cnt;
    logic [OUT_W-1:0] r_acc;
    logic             r_frame_done;
    logic             r_partial_drop;

    logic             w_last_lane;
    logic             w_full;
    logic             w_accept;
    logic             w_push;
    logic [OUT_W-1:0] w_word;
    logic [OUT_W-1:0] w_first;

    assign w_last_lane = (r_lane == LW'(RATIO - 1));
    // Only the final lane needs buffer space; a pop on this edge frees it.
    assign in_ready    = rst_n && !(w_last_lane && w_full && !out_ready);
    assign w_accept    = in_valid && in_ready;
    // frame_sync wins over a completing word: nothing is pushed.
    assign w_push      = w_accept && w_last_lane && !frame_sync;

    always_comb begin
        w_word = r_acc;
        for (int k = 0; k < RATIO; k++) begin
            if (r_lane == LW'(k))
                w_word[(MSB_FIRST ? (RATIO - 1 - k) : k) * IN_W +: IN_W] = in_data;
        end
    end

    // Word accepted together with frame_sync starts a fresh accumulator.
    always_comb begin
        w_first = '0;
        w_first[LANE0_LSB +: IN_W] = in_data;
    end

    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            r_lane         <= '0;
            r_frame_cnt    <= '0;
            r_acc          <= '0;
            r_frame_done   <= 1'b0;
            r_partial_drop <= 1'b0;
        end else begin
            r_frame_done   <= 1'b0;
            r_partial_drop <= 1'b0;
            if (frame_sync) begin
                r_partial_drop <= (r_lane != '0);
                if (w_accept) begin
                    r_acc       <= w_first;
                    r_lane      <= (RATIO > 1) ? LW'(1) : '0;
                    r_frame_cnt <= (FRAME_WORDS > 1) ? FW'(1) : '0;
                end else begin
                    r_acc       <= '0;
                    r_lane      <= '0;
                    r_frame_cnt <= '0;
                end
            end else if (w_accept) begin
                if (w_last_lane) begin
                    r_acc  <= '0;
                    r_lane <= '0;
                end else begin
                    r_acc  <= w_word;
                    r_lane <= r_lane + LW'(1);
                end
                if (r_frame_cnt == FW'(FRAME_WORDS - 1)) begin
                    r_frame_cnt  <= '0;
                    r_lane       <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FW'(1);
                end
            end
        end
    end

    sync_fifo_sa #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .i_clk       (clk_ref),
        .i_rst_n     (rst_n),
        .i_push      (w_push),
        .i_push_data (w_word),
        .i_pop       (out_ready),
        .o_data      (out_data),
        .o_valid     (out_valid),
        .o_full      (w_full),
        .o_count     (fill_level)
    );

    assign frame_done   = r_frame_done;
    assign partial_drop = r_partial_drop;

endmodule

// File: tb/tb_sdram_word_packer.sv
// Directed bench: three packers share one input stream.
//   a: defaults (MSB first), b: LSB first, c: 12-word frames.
module tb_sdram_word_packer;

    logic        clk_ref;
    logic        rst_n;
    logic        frame_sync;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        a_in_ready, b_in_ready, c_in_ready;
    logic        a_out_valid, b_out_valid, c_out_valid;
    logic [95:0] a_out_data, b_out_data, c_out_data;
    logic        a_frame_done, b_frame_done, c_frame_done;
    logic        a_partial_drop, b_partial_drop, c_partial_drop;
    logic [2:0]  a_fill_level, b_fill_level, c_fill_level;

    int checks = 0;
    int errors = 0;

    sdram_word_packer u_dut_a (
        .clk_ref(clk_ref), .rst_n(rst_n), .frame_sync(frame_sync),
        .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready),
        .frame_done(a_frame_done), .partial_drop(a_partial_drop), .fill_level(a_fill_level)
    );

    sdram_word_packer #(.MSB_FIRST(1'b0)) u_dut_b (
        .clk_ref(clk_ref), .rst_n(rst_n), .frame_sync(frame_sync),
        .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready),
        .frame_done(b_frame_done), .partial_drop(b_partial_drop), .fill_level(b_fill_level)
    );

    sdram_word_packer #(.FRAME_WORDS(12)) u_dut_c (
        .clk_ref(clk_ref), .rst_n(rst_n), .frame_sync(frame_sync),
        .in_valid(in_valid), .in_data(in_data), .in_ready(c_in_ready),
        .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(out_ready),
        .frame_done(c_frame_done), .partial_drop(c_partial_drop), .fill_level(c_fill_level)
    );

    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Six consecutive 16-bit values starting at 'first'.
    function automatic logic [95:0] pk(input int first, input bit msb);
        logic [95:0] r;
        logic [15:0] v;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            v = 16'(first + k);
            if (msb) r = {r[79:0], v};
            else     r = {v, r[95:16]};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic feed(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        frame_sync = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin : main
        int next;
        int outs;
        int c_done_cnt;
        int a_done_cnt;
        logic acc;

        rst_n = 1'b0; frame_sync = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // ---- reset state
        repeat (2) tick();
        chk("rst_a_in_ready", a_in_ready, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        chk("rst_c_in_ready", c_in_ready, 0);
        chk("rst_a_out", {a_out_valid, a_frame_done, a_partial_drop, a_fill_level, a_out_data}, 0);
        chk("rst_b_out", {b_out_valid, b_frame_done, b_partial_drop, b_fill_level, b_out_data}, 0);
        chk("rst_c_out", {c_out_valid, c_frame_done, c_partial_drop, c_fill_level, c_out_data}, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_a_in_ready", a_in_ready, 1);

        // ---- 1/2: basic packing, both lane orders
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) feed(16'(i));
        chk("t1_valid_before_last", a_out_valid, 0);
        feed(16'd6);
        chk("t1_valid_after_last", a_out_valid, 1);
        chk("t1_msb_data", a_out_data, 96'h0001_0002_0003_0004_0005_0006);
        chk("t2_lsb_data", b_out_data, 96'h0006_0005_0004_0003_0002_0001);
        chk("t2_lsb_valid", b_out_valid, 1);
        tick();
        chk("t1_popped", a_out_valid, 0);

        // ---- 3: backpressure
        do_reset();
        out_ready = 1'b0;
        next = 1;
        for (int c = 0; c < 30; c++) begin
            in_valid = 1'b1;
            in_data  = 16'(next);
            #1;
            acc = a_in_ready;
            tick();
            if (acc) next++;
        end
        chk("t3_accepted", next - 1, 29);
        chk("t3_fill_full", a_fill_level, 4);
        chk("t3_ready_low", a_in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("t3_ready_on_pop", a_in_ready, 1);
        chk("t3_head_w1", a_out_data, pk(1, 1'b1));
        tick();
        in_valid = 1'b0;
        chk("t3_fill_stays", a_fill_level, 4);
        for (int k = 2; k <= 5; k++) begin
            chk("t3_drain", a_out_data, pk(6 * (k - 1) + 1, 1'b1));
            tick();
        end
        chk("t3_empty", {a_out_valid, a_fill_level}, 0);

        // ---- 4: frame_sync realignment
        do_reset();
        out_ready = 1'b1;
        feed(16'h11); feed(16'h12); feed(16'h13);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("t4_partial_drop", a_partial_drop, 1);
        chk("t4_no_output", a_out_valid, 0);
        tick();
        chk("t4_drop_single", a_partial_drop, 0);
        for (int i = 0; i < 6; i++) feed(16'(16'hA1 + i));
        chk("t4_clean_valid", a_out_valid, 1);
        chk("t4_clean_word", a_out_data, pk(16'hA1, 1'b1));
        for (int i = 0; i < 5; i++) feed(16'(16'hB1 + i));
        in_valid = 1'b1; in_data = 16'hB6; frame_sync = 1'b1;
        tick();
        in_valid = 1'b0; frame_sync = 1'b0;
        chk("t4_sync_last_drop", a_partial_drop, 1);
        chk("t4_sync_last_nopush", a_out_valid, 0);
        for (int i = 0; i < 5; i++) feed(16'(16'hC1 + i));
        chk("t4_sync_word", a_out_data, 96'h00B6_00C1_00C2_00C3_00C4_00C5);

        // ---- 5: frame_done with 12-word frames
        do_reset();
        out_ready = 1'b1;
        outs = 0; c_done_cnt = 0; a_done_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            feed(16'(i));
            if (c_out_valid) outs++;
            if (c_frame_done) c_done_cnt++;
            if (a_frame_done) a_done_cnt++;
            if (i == 11) chk("t5_done_early", c_frame_done, 0);
            if (i == 12) chk("t5_done_pulse", c_frame_done, 1);
        end
        repeat (2) begin
            tick();
            if (c_out_valid) outs++;
            if (c_frame_done) c_done_cnt++;
        end
        chk("t5_outputs", outs, 2);
        chk("t5_done_count", c_done_cnt, 1);
        chk("t5_a_no_done", a_done_cnt, 0);
        for (int i = 13; i <= 18; i++) feed(16'(i));
        chk("t5_next_frame", c_out_data, pk(13, 1'b1));
        chk("t5_next_valid", c_out_valid, 1);

        // ---- 6: reset mid-word
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) feed(16'(16'h51 + i));
        rst_n = 1'b0;
        #1;
        chk("t6_ready_in_rst", a_in_ready, 0);
        repeat (2) tick();
        chk("t6_outs_in_rst", {a_out_valid, a_frame_done, a_partial_drop, a_fill_level, a_out_data}, 0);
        rst_n = 1'b1;
        #1;
        chk("t6_ready_release", a_in_ready, 1);
        for (int i = 0; i < 5; i++) feed(16'(16'h61 + i));
        chk("t6_no_residue_early", a_out_valid, 0);
        feed(16'h66);
        chk("t6_word", a_out_data, pk(16'h61, 1'b1));
        chk("t6_no_drop", a_partial_drop, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
